// File: rtl/byte_encode_stream.sv
// Streaming ByteEncode_D packer: 256 D-bit coefficients in, 32*D little-endian
// packed bytes out, through a 20-bit bit accumulator with valid/ready on both sides.
module byte_encode_stream #(
  parameter int D = 12,
  parameter int N = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [11:0] coeff_in,
  input  logic        coeff_valid,
  output logic        coeff_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready
);

  localparam int unsigned MASK_I = (1 << D) - 1;
  localparam logic [11:0] MASK   = MASK_I[11:0];
  localparam logic [8:0]  LAST   = 9'(32 * D - 1);
  localparam logic [8:0]  NCOEF  = 9'(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [19:0] acc;
  logic [4:0]  cnt;
  logic [8:0]  coef_cnt;
  logic [8:0]  byte_cnt;
  logic        coeff_hs;
  logic        byte_hs;
  logic [19:0] coeff_sh;

  // Handshake qualifiers come only from registered state, so coeff_ready
  // never depends combinationally on byte_ready or coeff_valid.
  assign coeff_ready = (state == RUN) && (coef_cnt < NCOEF) && (cnt < 5'd8);
  assign byte_valid  = (state == RUN) && (cnt >= 5'd8);
  assign byte_out    = acc[7:0];
  assign busy        = (state == RUN);
  assign done        = (state == DONE);

  assign coeff_hs = coeff_valid && coeff_ready;
  assign byte_hs  = byte_valid && byte_ready;
  // cnt < 8 on a coefficient handshake and D <= 12, so the result fits in 19 bits.
  assign coeff_sh = {8'b0, coeff_in & MASK} << cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      coef_cnt <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            acc      <= '0;
            cnt      <= '0;
            coef_cnt <= '0;
            byte_cnt <= '0;
          end
        end
        RUN: begin
          if (coeff_hs) begin
            acc      <= acc | coeff_sh;
            cnt      <= cnt + 5'(D);
            coef_cnt <= coef_cnt + 9'd1;
          end else if (byte_hs) begin
            acc      <= acc >> 8;
            cnt      <= cnt - 5'd8;
            byte_cnt <= byte_cnt + 9'd1;
            if (byte_cnt == LAST) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_encode_stream.sv
// Scoreboard bench: four packers (D = 12, 1, 4, 10) share one clock; a bit-level
// reference model queues expected bytes as coefficients are accepted.
module tb_byte_encode_stream;

  localparam int DS[4] = '{12, 1, 4, 10};

  logic       clk = 1'b0;
  logic       rst[4];
  logic       start[4];
  logic       busy[4];
  logic       done[4];
  logic [11:0] cin[4];
  logic       cval[4];
  logic       cready[4];
  logic [7:0] bout[4];
  logic       bval[4];
  logic       bready[4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    byte_encode_stream #(.D(DS[g]), .N(256)) u_dut (
      .clk(clk), .reset(rst[g]), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .coeff_in(cin[g]), .coeff_valid(cval[g]), .coeff_ready(cready[g]),
      .byte_out(bout[g]), .byte_valid(bval[g]), .byte_ready(bready[g])
    );
  end

  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] q[$];
  int         bitpos;
  logic [7:0] cur;
  int         coefs[256];
  logic [7:0] got[400];
  logic [7:0] ref_got[400];
  int         first_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream bit i*D+j lands at byte (i*D+j)/8, bit (i*D+j)%8.
  task automatic model_push(input int d, input int c);
    for (int j = 0; j < d; j++) begin
      cur[bitpos % 8] = 1'((c >> j) & 1);
      bitpos++;
      if (bitpos % 8 == 0) begin
        q.push_back(cur);
        cur = '0;
      end
    end
  endtask

  task automatic run_frame(input int sel, input int stall, input int noise,
                           input int abort, output int nb);
    int d, mask, idx, cyc, last_hs, h0, bv0;
    bit stalled, fin;
    logic [7:0] b;
    d = DS[sel]; mask = (1 << d) - 1;
    idx = 0; nb = 0; cyc = 0; last_hs = -10; h0 = -1; bv0 = -1;
    stalled = 0; fin = 0;
    bitpos = 0; cur = '0; q.delete();
    if (noise != 0) begin
      repeat (3) begin
        cval[sel] = 1'b1; cin[sel] = 12'($urandom);
        @(posedge clk); @(negedge clk);
        chk("idle_cready", 32'(cready[sel]), 0);
        chk("idle_busy", 32'(busy[sel]), 0);
      end
      cval[sel] = 1'b0;
    end
    start[sel] = 1'b1;
    @(posedge clk); @(negedge clk);
    start[sel] = 1'b0;
    chk("busy_start", 32'(busy[sel]), 1);
    while (!fin && cyc < 6000) begin
      if (done[sel]) begin
        chk("done_lat", cyc, last_hs + 1);
        fin = 1;
      end else begin
        if (bval[sel] && bv0 < 0) bv0 = cyc;
        if (stall != 0 && !stalled && nb == 10 && bval[sel]) begin
          stalled = 1; b = bout[sel];
          bready[sel] = 1'b0; cval[sel] = 1'b0;
          repeat (5) begin
            @(posedge clk); @(negedge clk); cyc++;
            chk("stall_out", 32'(bout[sel]), 32'(b));
            chk("stall_vld", 32'(bval[sel]), 1);
            chk("stall_cready", 32'(cready[sel]), 0);
          end
        end
        if (abort > 0 && idx == abort) begin
          rst[sel] = 1'b0; cval[sel] = 1'b0; bready[sel] = 1'b0;
          @(posedge clk); @(negedge clk);
          chk("abort_busy", 32'(busy[sel]), 0);
          chk("abort_done", 32'(done[sel]), 0);
          chk("abort_cready", 32'(cready[sel]), 0);
          chk("abort_bval", 32'(bval[sel]), 0);
          chk("abort_bout", 32'(bout[sel]), 0);
          rst[sel] = 1'b1;
          q.delete(); nb = 0;
          return;
        end
        cval[sel]   = (idx < 256) && ($urandom_range(0, 3) != 0);
        cin[sel]    = (idx < 256) ? 12'((coefs[idx] & mask) | ($urandom & ~mask)) : 12'h0;
        bready[sel] = ($urandom_range(0, 3) != 0);
        start[sel]  = (noise != 0) && (idx == 50);
        if (cval[sel] && cready[sel]) begin
          model_push(d, coefs[idx] & mask);
          if (h0 < 0) h0 = cyc;
          idx++;
        end
        if (bval[sel] && bready[sel]) begin
          if (q.size() > 0) chk("byte", 32'(bout[sel]), 32'(q.pop_front()));
          else chk("extra_byte", 1, 0);
          if (nb < 400) got[nb] = bout[sel];
          nb++; last_hs = cyc;
        end
        @(posedge clk); @(negedge clk); cyc++;
      end
    end
    cval[sel] = 1'b0; bready[sel] = 1'b0; start[sel] = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    @(posedge clk); @(negedge clk);
    chk("busy_after", 32'(busy[sel]), 0);
    chk("done_once", 32'(done[sel]), 0);
    chk("nbytes", nb, 32 * d);
    chk("q_empty", q.size(), 0);
    first_lat = bv0 - h0;
  endtask

  initial begin
    int nb;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b0; start[i] = 1'b0; cin[i] = '0; cval[i] = 1'b0; bready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_busy", 32'(busy[i]), 0);
      chk("rst_done", 32'(done[i]), 0);
      chk("rst_cready", 32'(cready[i]), 0);
      chk("rst_bval", 32'(bval[i]), 0);
      chk("rst_bout", 32'(bout[i]), 0);
      rst[i] = 1'b1;
    end

    // D=12: known leading pair, then latency of the first byte.
    for (int i = 0; i < 256; i++) coefs[i] = int'($urandom_range(0, 4095));
    coefs[0] = 'h123; coefs[1] = 'h456;
    run_frame(0, 0, 0, 0, nb);
    chk("d12_b0", 32'(got[0]), 'h23);
    chk("d12_b1", 32'(got[1]), 'h61);
    chk("d12_b2", 32'(got[2]), 'h45);
    chk("d12_lat", first_lat, 1);

    // D=1: alternating bits pack to 0x55.
    for (int i = 0; i < 256; i++) coefs[i] = (i % 2 == 0) ? 1 : 0;
    run_frame(1, 0, 0, 0, nb);
    for (int i = 0; i < 32; i++) chk("d1_55", 32'(got[i]), 'h55);

    // D=4: high bits discarded.
    for (int i = 0; i < 256; i++) coefs[i] = int'($urandom_range(0, 4095));
    coefs[0] = 'h0A3; coefs[1] = 'h0B5;
    run_frame(2, 0, 0, 0, nb);
    chk("d4_mask", 32'(got[0]), 'h53);

    // D=12 with a 5-cycle downstream stall.
    for (int i = 0; i < 256; i++) coefs[i] = int'($urandom_range(0, 4095));
    run_frame(0, 1, 0, 0, nb);
    chk("stall_total", nb, 384);

    // D=10: reset after 100 coefficients, then a clean frame.
    for (int i = 0; i < 256; i++) coefs[i] = int'($urandom_range(0, 1023));
    run_frame(3, 0, 0, 100, nb);
    run_frame(3, 0, 0, 0, nb);
    chk("d10_total", nb, 320);

    // Spurious start / idle coeff_valid must not alter the output stream.
    for (int i = 0; i < 256; i++) coefs[i] = int'($urandom_range(0, 4095));
    run_frame(0, 0, 0, 0, nb);
    for (int i = 0; i < 384; i++) ref_got[i] = got[i];
    run_frame(0, 0, 1, 0, nb);
    for (int i = 0; i < 384; i++) chk("noise_same", 32'(got[i]), 32'(ref_got[i]));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/byte_encode_stream.md
BYTE_ENCODE_STREAM -- requirements
Module: byte_encode_stream

Interface
REQ-001 Parameter D, default 12: coefficient bit width packed per coefficient; legal range 1..12.
REQ-002 Parameter N, default 256: coefficients per frame; fixed at 256.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins a frame when idle.
REQ-006 busy  output  1  high from accepted start until the last byte handshake.
REQ-007 done  output  1  one-cycle pulse after the last byte of a frame is transferred.
REQ-008 coeff_in  input  12  coefficient; only bits [D-1:0] are used.
REQ-009 coeff_valid  input  1  coeff_in is valid.
REQ-010 coeff_ready  output  1  the block accepts coeff_in this cycle.
REQ-011 byte_out  output  8  packed output byte.
REQ-012 byte_valid  output  1  byte_out is valid.
REQ-013 byte_ready  input  1  downstream accepts byte_out this cycle.

Function
REQ-014 Implements Kyber ByteEncode_D with little-endian bit order: bit j of coefficient i goes to stream bit i*D+j; byte k holds stream bits 8k..8k+7, with stream bit 8k at byte bit 0.
REQ-015 Each frame accepts exactly 256 coefficients and emits exactly 32*D bytes; no partial-byte flush is needed.
REQ-016 FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start.
- RUN -> DONE on the handshake of byte 32*D-1.
- DONE -> IDLE unconditionally after one cycle; done is high only in DONE.
REQ-017 Accumulator: 20-bit register acc plus 5-bit fill count cnt (0..19).
- Coefficient handshake (coeff_valid && coeff_ready): acc |= coeff[D-1:0] << cnt; cnt += D.
REQ-018 coeff_ready = (state==RUN) && (coef_cnt < 256) && (cnt < 8); it is registered-state derived and never depends combinationally on byte_ready or coeff_valid.
REQ-019 byte_valid = (state==RUN) && (cnt >= 8); byte_out = acc[7:0].
- Byte handshake: acc >>= 8; cnt -= 8.
REQ-020 Coefficient and byte handshakes are mutually exclusive by construction (cnt<8 vs cnt>=8); both are never applied in one cycle.
REQ-021 A coefficient accepted at cycle t that brings cnt >= 8 makes byte_valid high at t+1.
REQ-022 byte_out and byte_valid hold stable while byte_valid && !byte_ready.
REQ-023 coef_cnt (9 bits) counts accepted coefficients 0..256; byte_cnt counts transferred bytes 0..32*D-1.
REQ-024 start while busy or in DONE is ignored.
REQ-025 coeff_valid outside RUN, or after 256 coefficients, is ignored and has no state effect.
REQ-026 Bits of coeff_in above D-1 are discarded; there is no range check.

Reset
REQ-027 While reset==0 at a rising edge, the block enters IDLE and clears acc, cnt, coef_cnt and byte_cnt.
REQ-028 Output values under reset: busy=0, done=0, coeff_ready=0, byte_valid=0, byte_out=0.
REQ-029 Reset mid-frame abandons the frame with no further bytes emitted; the next start begins a clean frame.

Verification
REQ-030 D=12, start, first coefficients 0x123 then 0x456 -> bytes 0x23, 0x61, 0x45 in order; byte_valid first high one cycle after the 0x123 handshake.
REQ-031 D=1, 256 coefficients alternating 1,0 -> 32 bytes, all 0x55; done pulses once, one cycle after the 32nd byte handshake; busy then drops.
REQ-032 D=4, coefficients 0x0A3, 0x0B5 -> byte 0x53, confirming masking of high bits.
REQ-033 D=12, byte_ready held low for 5 cycles while byte_valid is high:
- byte_out stays stable and coeff_ready stays low;
- full-frame output matches the reference model with no lost or duplicated bytes;
- total bytes = 384.
REQ-034 D=10, reset pulled low after 100 coefficients -> all outputs 0 next cycle; a new start and full frame yields 320 bytes matching the model.
REQ-035 start pulsed mid-frame and coeff_valid asserted while IDLE -> no state change; the frame output is identical to the run without those pulses.
